// File: rtl/fetch_redirect_ctrl.sv
// Fetch-stage PC sequencer: free-running increment, stall hold, relative
// branch and absolute flush redirects, and a fixed-length squash window
// after every accepted redirect.
//
// state  | meaning
// -------+------------------------------------------------------------
// BOOT   | first cycle after reset; outputs held at reset values
// RUN    | fetching on the correct path; PC advances unless stalled
// SQUASH | bubble window after a redirect; PC holds the new target
module fetch_redirect_ctrl #(
    parameter int                  ADDR_W        = 16,
    parameter logic [ADDR_W-1:0]   RESET_PC      = '0,
    parameter int                  SQUASH_CYCLES = 2
) (
    input  logic              clock_i,
    input  logic              reset_i,
    input  logic              stall_i,
    input  logic              flushBack_i,
    input  logic [ADDR_W-1:0] flushTarget_i,
    input  logic              shouldBranch_i,
    input  logic [15:0]       branchOffset_i,
    input  logic              branchDirection_i,
    output logic [ADDR_W-1:0] pc_o,
    output logic              fetchValid_o,
    output logic              squash_o,
    output logic [1:0]        state_o,
    output logic [7:0]        redirectCount_o
);

    localparam logic [1:0] ST_BOOT   = 2'd0;
    localparam logic [1:0] ST_RUN    = 2'd1;
    localparam logic [1:0] ST_SQUASH = 2'd2;

    // Offsets are zero-extended before the add so they can never be read as negative.
    localparam int EXT_W = (ADDR_W > 16) ? ADDR_W : 16;

    logic [EXT_W-1:0]  offset_wide;
    logic [ADDR_W-1:0] offset_ext;
    logic [ADDR_W-1:0] branch_target;
    logic              redirect;
    logic [3:0]        squash_cnt;

    logic [1:0]        state_nxt;
    logic [ADDR_W-1:0] pc_nxt;
    logic [3:0]        squash_cnt_nxt;
    logic [7:0]        redirect_cnt_nxt;

    // Branch target arithmetic; wraps modulo 2^ADDR_W in both directions.
    always_comb begin
        offset_wide   = EXT_W'(branchOffset_i);
        offset_ext    = offset_wide[ADDR_W-1:0];
        branch_target = branchDirection_i ? (pc_o + offset_ext) : (pc_o - offset_ext);
    end

    // Next-state logic: redirects win over everything except BOOT, flush beats branch.
    always_comb begin
        state_nxt        = state_o;
        pc_nxt           = pc_o;
        squash_cnt_nxt   = squash_cnt;
        redirect_cnt_nxt = redirectCount_o;
        redirect         = (flushBack_i || shouldBranch_i) && (state_o != ST_BOOT);

        if (state_o == ST_BOOT) begin
            state_nxt = ST_RUN;
        end else if (redirect) begin
            pc_nxt         = flushBack_i ? flushTarget_i : branch_target;
            state_nxt      = ST_SQUASH;
            squash_cnt_nxt = 4'(SQUASH_CYCLES);
            if (redirectCount_o != 8'hFF) begin
                redirect_cnt_nxt = redirectCount_o + 8'd1;
            end
        end else if (state_o == ST_RUN) begin
            if (!stall_i) begin
                pc_nxt = pc_o + ADDR_W'(1);
            end
        end else begin
            // Squash counts down even while stalled; last bubble hands over to RUN.
            squash_cnt_nxt = squash_cnt - 4'd1;
            if (squash_cnt == 4'd1) begin
                state_nxt = ST_RUN;
            end
        end
    end

    // All outputs are flops; fetch-valid and squash are decoded from the next state.
    always_ff @(posedge clock_i or negedge reset_i) begin
        if (!reset_i) begin
            state_o         <= ST_BOOT;
            pc_o            <= RESET_PC;
            squash_cnt      <= 4'd0;
            redirectCount_o <= 8'd0;
            fetchValid_o    <= 1'b0;
            squash_o        <= 1'b0;
        end else begin
            state_o         <= state_nxt;
            pc_o            <= pc_nxt;
            squash_cnt      <= squash_cnt_nxt;
            redirectCount_o <= redirect_cnt_nxt;
            fetchValid_o    <= (state_nxt == ST_RUN);
            squash_o        <= (state_nxt == ST_SQUASH);
        end
    end

endmodule

// File: tb/tb_fetch_redirect_ctrl.sv
// Randomised and directed bench for fetch_redirect_ctrl with a scoreboard:
// the driver pushes the expected post-edge outputs from a behavioural model,
// a separate monitor pops and compares them just after every rising edge.
module tb_fetch_redirect_ctrl;

    localparam int SQC = 2;

    logic        clock_i = 1'b0;
    logic        reset_i = 1'b0;
    logic        stall_i = 1'b0;
    logic        flushBack_i = 1'b0;
    logic [15:0] flushTarget_i = '0;
    logic        shouldBranch_i = 1'b0;
    logic [15:0] branchOffset_i = '0;
    logic        branchDirection_i = 1'b0;
    logic [15:0] pc_o;
    logic        fetchValid_o;
    logic        squash_o;
    logic [1:0]  state_o;
    logic [7:0]  redirectCount_o;

    fetch_redirect_ctrl #(.ADDR_W(16), .RESET_PC(16'h0000), .SQUASH_CYCLES(SQC)) dut (
        .clock_i(clock_i), .reset_i(reset_i), .stall_i(stall_i),
        .flushBack_i(flushBack_i), .flushTarget_i(flushTarget_i),
        .shouldBranch_i(shouldBranch_i), .branchOffset_i(branchOffset_i),
        .branchDirection_i(branchDirection_i), .pc_o(pc_o),
        .fetchValid_o(fetchValid_o), .squash_o(squash_o), .state_o(state_o),
        .redirectCount_o(redirectCount_o)
    );

    always #5 clock_i = ~clock_i;

    typedef struct {
        int pc;
        int fv;
        int sq;
        int st;
        int cnt;
    } exp_t;

    exp_t exp_q[$];
    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: mode 0 boot, 1 run, 2 squash; bubbles = squash cycles still to show.
    int m_pc = 0, m_mode = 0, m_bubbles = 0, m_cnt = 0;

    task automatic check(input string name, input int act, input int expv);
        n_tests++;
        if (act != expv) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, expv, $time);
        end
    endtask

    function automatic void model_step(input bit rst, input bit fl, input int tgt,
                                       input bit br, input int off, input bit dir,
                                       input bit st);
        int t;
        if (!rst) begin
            m_pc = 0; m_mode = 0; m_bubbles = 0; m_cnt = 0;
        end else if (m_mode == 0) begin
            m_mode = 1;
        end else if (fl || br) begin
            if (fl) t = tgt;
            else    t = dir ? (m_pc + off) : (m_pc - off);
            m_pc = ((t % 65536) + 65536) % 65536;
            m_mode = 2;
            m_bubbles = SQC;
            if (m_cnt < 255) m_cnt = m_cnt + 1;
        end else if (m_mode == 1) begin
            if (!st) m_pc = (m_pc + 1) % 65536;
        end else begin
            m_bubbles = m_bubbles - 1;
            if (m_bubbles == 0) m_mode = 1;
        end
    endfunction

    // Called at a falling edge: drive inputs for the next rising edge, predict, then advance.
    task automatic step(input bit rst, input bit fl, input bit [15:0] tgt, input bit br,
                        input bit [15:0] off, input bit dir, input bit st);
        exp_t e;
        reset_i = rst; flushBack_i = fl; flushTarget_i = tgt; shouldBranch_i = br;
        branchOffset_i = off; branchDirection_i = dir; stall_i = st;
        model_step(rst, fl, int'(tgt), br, int'(off), dir, st);
        e.pc = m_pc; e.fv = (m_mode == 1); e.sq = (m_mode == 2); e.st = m_mode; e.cnt = m_cnt;
        exp_q.push_back(e);
        if (!rst) begin
            #1;
            check("async_rst_pc", int'(pc_o), 0);
            check("async_rst_state", int'(state_o), 0);
            check("async_rst_fv", int'(fetchValid_o), 0);
            check("async_rst_sq", int'(squash_o), 0);
            check("async_rst_cnt", int'(redirectCount_o), 0);
        end
        @(negedge clock_i);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1, 0, 16'h0, 0, 16'h0, 0, 0);
    endtask

    task automatic wait_pc(input int target);
        int n = 0;
        while (!(m_pc == target && m_mode == 1) && n < 200) begin
            idle(1);
            n++;
        end
        if (n >= 200) begin
            n_tests++; n_fail++;
            $display("FAIL wait_pc: pc never reached 0x%0h (model at 0x%0h)", target, m_pc);
        end
    endtask

    // Monitor: compare DUT outputs with the oldest prediction just after each rising edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clock_i);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("sb_pc", int'(pc_o), e.pc);
                check("sb_fetch_valid", int'(fetchValid_o), e.fv);
                check("sb_squash", int'(squash_o), e.sq);
                check("sb_state", int'(state_o), e.st);
                check("sb_redirect_cnt", int'(redirectCount_o), e.cnt);
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        int r;
        bit fl, br, st, dir, rs;
        bit [15:0] off, tgt;
        @(negedge clock_i);

        // 1: reset 3 cycles, boot, then free-running fetch
        for (int i = 0; i < 3; i++) step(0, 0, 16'h0, 0, 16'h0, 0, 0);
        idle(1);
        check("boot_exit_pc", int'(pc_o), 0);
        check("boot_exit_fv", int'(fetchValid_o), 1);
        wait_pc(10);

        // 2: forward branch 10 from 10
        step(1, 0, 16'h0, 1, 16'd10, 1, 0);
        check("br_fwd_pc", int'(pc_o), 20);
        check("br_fwd_squash", int'(squash_o), 1);
        idle(2);
        check("br_fwd_run_fv", int'(fetchValid_o), 1);
        check("br_fwd_count", int'(redirectCount_o), 1);

        // 3: backward branches including wrap below zero, forward wrap above max
        wait_pc(22);
        step(1, 0, 16'h0, 1, 16'd20, 0, 0);
        check("br_back_pc", int'(pc_o), 2);
        wait_pc(5);
        step(1, 0, 16'h0, 1, 16'd20, 0, 0);
        check("br_back_wrap_pc", int'(pc_o), 16'hFFF1);
        wait_pc(16'hFFFE);
        step(1, 0, 16'h0, 1, 16'd3, 1, 0);
        check("br_fwd_wrap_pc", int'(pc_o), 1);

        // 4: flush and branch together, flush wins and counts once
        wait_pc(3);
        step(1, 1, 16'h0100, 1, 16'd4, 1, 0);
        check("flush_prio_pc", int'(pc_o), 16'h0100);
        check("flush_prio_count", int'(redirectCount_o), 5);

        // 5: stall hold, then branch during stall with squash counting down while stalled
        wait_pc(16'h0102);
        for (int i = 0; i < 4; i++) step(1, 0, 16'h0, 0, 16'h0, 0, 1);
        check("stall_hold_pc", int'(pc_o), 16'h0102);
        step(1, 0, 16'h0, 1, 16'd0, 1, 1);
        check("br_zero_pc", int'(pc_o), 16'h0102);
        step(1, 0, 16'h0, 0, 16'h0, 0, 1);
        step(1, 0, 16'h0, 0, 16'h0, 0, 1);
        check("stalled_squash_done", int'(fetchValid_o), 1);
        idle(2);

        // 6: back-to-back branches restart the squash; reset mid-squash
        wait_pc(16'h0105);
        step(1, 0, 16'h0, 1, 16'd7, 1, 0);
        step(1, 0, 16'h0, 1, 16'd100, 1, 0);
        check("restart_pc", int'(pc_o), 16'h0170);
        step(1, 0, 16'h0, 0, 16'h0, 0, 0);
        check("restart_still_squash", int'(squash_o), 1);
        step(0, 0, 16'h0, 0, 16'h0, 0, 0);
        idle(3);

        // Saturation of the redirect counter
        for (int i = 0; i < 270; i++) step(1, 1, 16'($urandom), 0, 16'h0, 0, 0);
        check("count_saturated", int'(redirectCount_o), 255);
        idle(3);

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            r   = $urandom_range(0, 99);
            rs  = (r >= 2);
            fl  = ($urandom_range(0, 99) < 8);
            br  = ($urandom_range(0, 99) < 15);
            st  = ($urandom_range(0, 99) < 30);
            dir = 1'($urandom);
            off = ($urandom_range(0, 9) == 0) ? 16'd0 : 16'($urandom);
            tgt = 16'($urandom);
            step(rs, fl, tgt, br, off, dir, st);
        end
        idle(2);

        for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(negedge clock_i);
        if (exp_q.size() > 0) begin
            n_tests++; n_fail++;
            $display("FAIL drain: %0d predictions left unchecked, expected 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
